// File: rtl/bus_dma.sv
// Word-copy DMA initiator for the peripheral bus.
// Reads one word, holds it, writes it, and repeats len times.
module bus_dma #(
  parameter int DW = 16,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] xfer_cnt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, DONE, ABT
  } state_t;

  state_t        state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nx;
  logic [DW-1:0] hold;

  assign idx_nx    = idx + AW'(1);
  assign bus_wdata = hold;

  // Outputs are registered alongside the state they belong to,
  // so each output cycle lines up exactly with its state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      bus_we   <= 1'b0;
      bus_addr <= '0;
      xfer_cnt <= '0;
      hold     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      bus_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          bus_addr <= '0;
          if (start) begin
            src_q    <= src;
            dst_q    <= dst;
            len_q    <= len;
            xfer_cnt <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RD;
              bus_addr <= src;
            end
          end
        end
        RD: begin
          if (abort) begin
            state    <= ABT;
            aborted  <= 1'b1;
            bus_addr <= '0;
          end else begin
            state <= CAP;
          end
        end
        CAP: begin
          hold <= bus_rdata;
          if (abort) begin
            state    <= ABT;
            aborted  <= 1'b1;
            bus_addr <= '0;
          end else begin
            state    <= WR;
            bus_addr <= dst_q + idx;
            bus_we   <= 1'b1;
          end
        end
        WR: begin
          xfer_cnt <= xfer_cnt + AW'(1);
          idx      <= idx_nx;
          if (abort) begin
            state    <= ABT;
            aborted  <= 1'b1;
            bus_addr <= '0;
          end else if (idx_nx == len_q) begin
            state    <= DONE;
            done     <= 1'b1;
            bus_addr <= '0;
          end else begin
            state    <= RD;
            bus_addr <= src_q + idx_nx;
          end
        end
        DONE, ABT: begin
          state    <= IDLE;
          busy     <= 1'b0;
          bus_addr <= '0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          bus_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: registered-read peripheral model plus a
// cycle-schedule reference model of each copy.
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [12:0] src, dst, len;
  logic        busy, done, aborted, bus_we;
  logic [12:0] xfer_cnt, bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] rdata;

  int errors = 0;
  int checks = 0;

  bus_dma #(.DW(16), .AW(13)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .aborted(aborted),
    .xfer_cnt(xfer_cnt), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(rdata)
  );

  always #5 clk = ~clk;

  // Peripheral: reads registered, writes committed at the edge.
  logic [15:0] mem [8192];
  logic        fill = 1'b0;
  logic        pk = 1'b0;
  logic [12:0] pk_a = '0;
  logic [15:0] pk_d = '0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 40503 + 7);
    end else if (pk) begin
      mem[pk_a] = pk_d;
    end else if (bus_we) begin
      mem[bus_addr] = bus_wdata;
    end else begin
      rdata <= mem[bus_addr];
    end
  end

  logic [15:0] ref_mem [8192];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model for the transfer in flight.
  logic [12:0] ms, md, ml;
  logic [15:0] wq [$];
  logic [12:0] rlog [$];
  logic [12:0] wlog_a [$];
  logic [15:0] wlog_d [$];
  bit          track = 0;
  bit          fin = 0;
  bit          chk_en = 0;
  bit          busy_last = 0;
  int          cyc = 0;
  int          done_cyc = -1;

  // Cycle k after the start edge: RD at 3w+1, CAP at 3w+2,
  // WR at 3w+3 for word w, done at 3*len+1.
  always begin : compare
    logic st_s;
    int   n;
    int   w;
    @(posedge clk);
    st_s = start;
    #2;
    if (rst) begin
      track = 0;
    end else if (chk_en) begin
      if (track) cyc++;
      else if (st_s && !busy_last) begin
        track = 1;
        cyc = 1;
      end
      n = 3 * int'(ml) + 1;
      if (track && cyc > n) begin
        track = 0;
        fin = 1;
      end
      if (track) begin
        chk("busy", busy, 1);
        chk("aborted", aborted, 0);
        chk("done", done, cyc == n);
        chk("we", bus_we, (cyc % 3 == 0) && cyc < n);
        if (cyc % 3 == 1 && cyc < n) begin
          w = (cyc - 1) / 3;
          chk("rd_addr", bus_addr, 13'(ms + 13'(w)));
          rlog.push_back(bus_addr);
        end
        if (bus_we) begin
          wlog_a.push_back(bus_addr);
          wlog_d.push_back(bus_wdata);
        end
        if (cyc % 3 == 0 && cyc < n) begin
          w = cyc / 3 - 1;
          chk("wr_addr", bus_addr, 13'(md + 13'(w)));
          chk("wr_data", bus_wdata, wq[w]);
        end
        if (done) done_cyc = cyc;
        if (cyc == n) chk("xfer_cnt", xfer_cnt, ml);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_we", bus_we, 0);
        chk("idle_done", done, 0);
        chk("idle_abt", aborted, 0);
        chk("idle_addr", bus_addr, 0);
      end
    end
    busy_last = busy;
  end

  task automatic poke(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    pk = 1'b1;
    pk_a = a;
    pk_d = d;
    @(negedge clk);
    pk = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_xfer(input logic [12:0] s, input logic [12:0] d,
                          input logic [12:0] l, input bit bstart);
    logic [15:0] v;
    ms = s;
    md = d;
    ml = l;
    wq.delete();
    rlog.delete();
    wlog_a.delete();
    wlog_d.delete();
    done_cyc = -1;
    for (int k = 0; k < int'(l); k++) begin
      v = ref_mem[13'(s + 13'(k))];
      ref_mem[13'(d + 13'(k))] = v;
      wq.push_back(v);
    end
    fin = 0;
    chk_en = 1;
    @(negedge clk);
    src = s;
    dst = d;
    len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src = 13'($urandom);
    dst = 13'($urandom);
    len = 13'($urandom);
    if (bstart && l != 0) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 3 * int'(l) + 12 && !fin; t++) @(negedge clk);
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy want done within budget");
    end
    @(negedge clk);
  endtask

  initial begin : main
    int nwr, ndone, nab;
    logic [12:0] wa [$];
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    fill = 1'b1;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 16'(i * 40503 + 7);
    #7;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abt", aborted, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_cnt", xfer_cnt, 0);
    @(negedge clk);
    fill = 1'b0;
    rst = 1'b0;

    // Single word copy
    poke(13'd0, 16'hA5C3);
    run_xfer(13'd0, 13'd1, 13'd1, 0);
    chk("t1_nwr", wlog_a.size(), 1);
    chk("t1_addr", wlog_a[0], 1);
    chk("t1_data", wlog_d[0], 16'hA5C3);
    chk("t1_rd", rlog[0], 0);
    chk("t1_donecyc", done_cyc, 4);
    chk("t1_cnt", xfer_cnt, 1);
    chk("t1_mem", mem[1], 16'hA5C3);

    // Four words 10..13 -> 20..23
    for (int k = 0; k < 4; k++)
      poke(13'(10 + k), 16'(16'h1111 * (k + 1)));
    run_xfer(13'd10, 13'd20, 13'd4, 1);
    chk("t2_nwr", wlog_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_addr", wlog_a[k], 20 + k);
      chk("t2_data", wlog_d[k], 16'h1111 * (k + 1));
    end
    chk("t2_donecyc", done_cyc, 13);
    repeat (3) @(negedge clk);
    chk("t2_cnt_hold", xfer_cnt, 4);

    // Zero length
    run_xfer(13'd5, 13'd6, 13'd0, 0);
    chk("t3_nwr", wlog_a.size(), 0);
    chk("t3_donecyc", done_cyc, 1);
    chk("t3_cnt", xfer_cnt, 0);

    // Address wrap
    run_xfer(13'h1FFE, 13'h1FFF, 13'd3, 0);
    chk("t4_r0", rlog[0], 13'h1FFE);
    chk("t4_r1", rlog[1], 13'h1FFF);
    chk("t4_r2", rlog[2], 13'h0000);
    chk("t4_w0", wlog_a[0], 13'h1FFF);
    chk("t4_w1", wlog_a[1], 13'h0000);
    chk("t4_w2", wlog_a[2], 13'h0001);

    // Random copies, some with a stray start while busy
    for (int r = 0; r < 20; r++)
      run_xfer(13'($urandom), 13'($urandom),
               13'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));

    // Abort during the write of the third word
    chk_en = 0;
    wa.delete();
    nwr = 0;
    ndone = 0;
    nab = 0;
    @(negedge clk);
    src = 13'd100;
    dst = 13'd200;
    len = 13'd8;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #2;
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        start = 1'b1;
        src = 13'd7;
        dst = 13'd9;
        len = 13'd2;
      end
      if (c == 4) start = 1'b0;
      if (bus_we) begin
        nwr++;
        wa.push_back(bus_addr);
      end
      if (done) ndone++;
      if (aborted) begin
        nab++;
        chk("ab_cyc", c, 10);
      end
      if (c == 9) begin
        chk("ab_wr_live", bus_we, 1);
        abort = 1'b1;
      end
      if (c == 10) abort = 1'b0;
    end
    for (int k = 0; k < 3; k++) ref_mem[200 + k] = ref_mem[100 + k];
    chk("ab_nwr", nwr, 3);
    chk("ab_ndone", ndone, 0);
    chk("ab_nab", nab, 1);
    chk("ab_cnt", xfer_cnt, 3);
    chk("ab_busy", busy, 0);
    for (int k = 0; k < 3; k++) chk("ab_addr", wa[k], 200 + k);
    chk("ab_mem", mem[202], ref_mem[102]);

    // Reset asserted between edges during CAP
    @(negedge clk);
    src = 13'd300;
    dst = 13'd400;
    len = 13'd4;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(posedge clk);
    #2;
    chk("rs_cap_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_we", bus_we, 0);
    chk("rs_addr", bus_addr, 0);
    chk("rs_cnt", xfer_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    nwr = 0;
    ndone = 0;
    nab = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_we) nwr++;
      if (done) ndone++;
      if (aborted) nab++;
    end
    chk("rs_nwr", nwr, 0);
    chk("rs_ndone", ndone, 0);
    chk("rs_nab", nab, 0);

    // Normal operation afterwards
    run_xfer(13'd500, 13'd600, 13'd3, 0);
    chk("post_nwr", wlog_a.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 The module SHALL have parameter DW, default 16, meaning peripheral bus data width.
REQ-002 The module SHALL have parameter AW, default 13, meaning peripheral bus address width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The module SHALL have port start, input, 1, launch a transfer when sampled high in IDLE.
REQ-006 The module SHALL have port abort, input, 1, cancel an in-progress transfer.
REQ-007 The module SHALL have port src, input, AW, first source word address.
REQ-008 The module SHALL have port dst, input, AW, first destination word address.
REQ-009 The module SHALL have port len, input, AW, number of words to copy.
REQ-010 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The module SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-012 The module SHALL have port aborted, output, 1, one-cycle pulse on abort completion.
REQ-013 The module SHALL have port xfer_cnt, output, AW, count of words written in the current or last transfer.
REQ-014 The module SHALL have port bus_addr, output, AW, address to peripheral.
REQ-015 The module SHALL have port bus_wdata, output, DW, write data to peripheral.
REQ-016 The module SHALL have port bus_we, output, 1, high-level write enable to peripheral.
REQ-017 The module SHALL have port bus_rdata, input, DW, read data from peripheral.

Function
REQ-018 The module SHALL act as bus initiator for the team's memory-mapped peripherals: read registered by the responder, valid the cycle after the address is presented with bus_we=0; write committed at the edge ending a bus_we=1 cycle.
REQ-019 The module SHALL implement states IDLE, RD, CAP, WR, DONE, ABT.
REQ-020 In IDLE, start=1 SHALL latch src, dst, and len, clear xfer_cnt and the word index i, and go to DONE if len=0, else RD.
REQ-021 RD SHALL drive bus_addr=src+i, bus_we=0 for one cycle, then go to CAP.
REQ-022 CAP SHALL drive bus_we=0 and capture bus_rdata into an internal hold register at its ending edge, then go to WR.
REQ-023 WR SHALL drive bus_addr=dst+i, bus_wdata=hold, bus_we=1 for exactly one cycle.
REQ-024 At the edge ending WR, xfer_cnt and i SHALL increment, and the state SHALL go to DONE if i+1=len, else RD.
REQ-025 DONE SHALL assert done for one cycle, then go to IDLE; ABT SHALL assert aborted for one cycle, then go to IDLE.
REQ-026 bus_we SHALL be high only in WR; bus_addr, bus_wdata, bus_we, busy, done, and aborted SHALL depend only on registered state, with no combinational input-to-output path.
REQ-027 In IDLE, DONE, and ABT, bus_addr SHALL be 0 and bus_we SHALL be 0, and bus_wdata SHALL hold its last value.
REQ-028 Address sums SHALL be computed modulo 2^AW and wrap silently, e.g. src=13'h1FFF with i=1 gives address 0.
REQ-029 Latency SHALL be 3*len+2 cycles from the start-sampling edge to the end of the done pulse; the done cycle begins 3*len+1 cycles after the start-sampling edge.
REQ-030 A start pulse while busy SHALL be ignored and SHALL NOT alter the latched parameters.
REQ-031 abort sampled high in RD, CAP, or WR SHALL move the state to ABT at that edge.
REQ-032 A WR cycle coinciding with abort SHALL still complete its write and SHALL count in xfer_cnt.
REQ-033 abort in IDLE, DONE, or ABT SHALL be ignored.
REQ-034 When start and abort are both high in IDLE, start SHALL win.
REQ-035 xfer_cnt SHALL hold its value after DONE or ABT until the next accepted start.

Reset
REQ-036 Asserting rst SHALL immediately force the following, regardless of clk: state=IDLE, busy=0, done=0, aborted=0, bus_we=0, bus_addr=0, bus_wdata=0, xfer_cnt=0, hold=0.
REQ-037 rst asserted mid-transfer SHALL abandon the transfer with no done or aborted pulse, and no further bus_we cycle SHALL occur until a new start.

Verification
REQ-038 The bench SHALL cover normal copy: src=0, dst=1, len=1, peripheral at addr 0 returns 16'hA5C3 -> one read of addr 0, one write of 16'hA5C3 to addr 1, done pulses exactly 4 cycles after the start edge, xfer_cnt=1.
REQ-039 The bench SHALL cover a multi-word copy: src=10, dst=20, len=4 from a memory model -> writes to addresses 20..23 in order with matching data, done after 13 cycles, xfer_cnt=4.
REQ-040 The bench SHALL cover zero length: len=0, start -> no bus_we ever, done pulses the next cycle, xfer_cnt=0.
REQ-041 The bench SHALL cover wrap: src=13'h1FFE, dst=13'h1FFF, len=3 -> read addresses 1FFE, 1FFF, 0000 and write addresses 1FFF, 0000, 0001.
REQ-042 The bench SHALL cover abort: len=8, abort during the WR of word 3 -> that write occurs, aborted pulses, done never pulses, xfer_cnt=3, and a start pulse while busy is ignored.
REQ-043 The bench SHALL cover reset mid-transfer: rst asserted between clock edges during CAP -> bus_we=0 and busy=0 immediately, with no done or aborted pulse.
